// File: rtl/fifo_pkg.sv
// Shared constants for the per-lane threshold FIFO.
//   FIFO_DATA_WIDTH : default data word width
//   FIFO_ADDR_WIDTH : default log2 depth, also the threshold width
//   FIFO_DEPTH      : number of storage words
package fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 6;
  localparam int unsigned FIFO_ADDR_WIDTH = 3;
  localparam int unsigned FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;

endpackage

// File: rtl/fifo_mem.sv
// Dual-port register array for fifo_umbral.
// The write side is synchronous. The read side captures the addressed word
// into an output register when rd_en is high, and holds it otherwise.
// The array contents are not reset. Only the output register is reset.
// Ports:
//   clk     : rising-edge clock
//   reset   : asynchronous active-low reset, clears rd_data
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_en   : read strobe, loads rd_data
//   rd_addr : read address
//   rd_data : registered read data
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // When a simultaneous read and write hit the same address (full FIFO,
  // push and pop together), the read returns the old word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_umbral.sv
// Per-lane data FIFO with programmable almost-full/almost-empty thresholds.
// The thresholds come from the configuration FSM's latched values.
// fifo_empty feeds back into the FSM's FIFO_empty bus.
//
// Compile-time option: FIFO_REG_FLAGS_EN
//   When this macro is defined, the status flags are registered. They are
//   computed from the next count and the current thresholds.
//   When it is undefined, the flags are combinational from count and the
//   live thresholds.
//
// Ports:
//   clk          : rising-edge clock
//   reset        : asynchronous active-low reset
//   push, pop    : write / read requests
//   data_in      : write data
//   umbral_alto  : almost-full threshold  (flag when occupancy >= threshold)
//   umbral_bajo  : almost-empty threshold (flag when occupancy <= threshold)
//   data_out     : registered read data, one cycle after an accepted pop
//   valid_out    : data_out carries a newly popped word this cycle
//   fifo_empty   : occupancy == 0
//   fifo_full    : occupancy == depth
//   almost_full  : occupancy >= umbral_alto
//   almost_empty : occupancy <= umbral_bajo
//   error        : sticky overflow/underflow, cleared only by reset
module fifo_umbral
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] umbral_alto,
  input  logic [ADDR_WIDTH-1:0] umbral_bajo,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam int unsigned DEPTH_I = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH   = DEPTH_I[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  is_empty;
  logic                  is_full;
  logic                  push_acc;
  logic                  pop_acc;
  logic                  bad_req;

  // Acceptance uses the count directly. This keeps it independent of
  // whether the exported flags are registered.
  assign is_empty = (count == '0);
  assign is_full  = (count == DEPTH);
  assign pop_acc  = pop && !is_empty;
  assign push_acc = push && (!is_full || pop_acc);
  assign bad_req  = (push && !push_acc) || (pop && !pop_acc);

  always_comb begin
    count_next = count;
    case ({push_acc, pop_acc})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_acc)  rd_ptr <= rd_ptr + PTR_ONE;
      count     <= count_next;
      valid_out <= pop_acc;
      if (bad_req) error <= 1'b1;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_acc),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (pop_acc),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

`ifdef FIFO_REG_FLAGS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_empty   <= 1'b1;
      fifo_full    <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
    end else begin
      fifo_empty   <= (count_next == '0);
      fifo_full    <= (count_next == DEPTH);
      almost_empty <= (count_next <= {1'b0, umbral_bajo});
      almost_full  <= (count_next >= {1'b0, umbral_alto});
    end
  end
`else
  assign fifo_empty   = is_empty;
  assign fifo_full    = is_full;
  assign almost_empty = (count <= {1'b0, umbral_bajo});
  assign almost_full  = (count >= {1'b0, umbral_alto});
`endif

endmodule

// File: tb/tb_fifo_umbral.sv
// Scoreboard bench for fifo_umbral. A queue-based reference model predicts
// the popped words and the status flags. A separate monitor checks every
// valid_out word against the expected-data queue.
module tb_fifo_umbral;

  logic       clk = 1'b0;
  logic       reset;
  logic       push, pop;
  logic [5:0] data_in;
  logic [2:0] umbral_alto, umbral_bajo;
  logic [5:0] data_out;
  logic       valid_out, fifo_empty, fifo_full, almost_full, almost_empty, error;

  int passed = 0;
  int total  = 0;

  // reference model state
  int  mq[$];        // stored words, oldest first
  int  expq[$];      // words expected on data_out
  bit  m_err;
  bit  m_fe, m_ff, m_ae, m_af;  // registered-flag model

  fifo_umbral #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_flags();
`ifdef FIFO_REG_FLAGS_EN
    chk("fifo_empty",   fifo_empty,   m_fe);
    chk("fifo_full",    fifo_full,    m_ff);
    chk("almost_empty", almost_empty, m_ae);
    chk("almost_full",  almost_full,  m_af);
`else
    chk("fifo_empty",   fifo_empty,   mq.size() == 0);
    chk("fifo_full",    fifo_full,    mq.size() == 8);
    chk("almost_empty", almost_empty, mq.size() <= int'(umbral_bajo));
    chk("almost_full",  almost_full,  mq.size() >= int'(umbral_alto));
`endif
    chk("error", error, m_err);
  endtask

  task automatic model_reset();
    mq.delete();
    expq.delete();
    m_err = 0;
    m_fe = 1; m_ff = 0; m_ae = 1; m_af = 0;
  endtask

  // One clock cycle: check the settled outputs at the negedge, drive new
  // inputs, then advance the model at the posedge using those inputs.
  task automatic step(input bit p, input bit q, input int d, input int ua, input int ub);
    bit pa, pu;
    @(negedge clk);
    check_flags();
    push = p; pop = q; data_in = 6'(d);
    umbral_alto = 3'(ua); umbral_bajo = 3'(ub);
    @(posedge clk);
    pa = q && (mq.size() > 0);
    pu = p && (mq.size() < 8 || pa);
    if (pa) expq.push_back(mq.pop_front());
    if (pu) mq.push_back(d);
    if ((p && !pu) || (q && !pa)) m_err = 1;
    m_fe = (mq.size() == 0);
    m_ff = (mq.size() == 8);
    m_ae = (mq.size() <= ub);
    m_af = (mq.size() >= ua);
  endtask

  // monitor: valid_out must match pending expectations, and data must match
  always @(negedge clk) begin
    if (reset) begin
      chk("valid_out", valid_out, expq.size() > 0);
      if (valid_out && expq.size() > 0) chk("data_out", data_out, expq.pop_front());
    end
  end

  int ua_r, ub_r;

  initial begin
    reset = 1'b0; push = 0; pop = 0; data_in = '0;
    umbral_alto = 3'd5; umbral_bajo = 3'd1;
    model_reset();
    #3;
    chk("rst fifo_empty",   fifo_empty,   1);
    chk("rst almost_empty", almost_empty, 1);
    chk("rst almost_full",  almost_full,  0);
    chk("rst error",        error,        0);
    chk("rst valid_out",    valid_out,    0);
    chk("rst data_out",     data_out,     0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // five pushes, then five pops
    step(1, 0, 'h11, 5, 1);
    step(1, 0, 'h22, 5, 1);
    step(1, 0, 'h33, 5, 1);
    step(1, 0, 'h04, 5, 1);
    step(1, 0, 'h05, 5, 1);
    repeat (5) step(0, 1, 0, 5, 1);

    // fill to 8, then overflow, then push and pop together while full
    for (int i = 0; i < 8; i++) step(1, 0, 8 + i, 5, 1);
    step(1, 0, 'h3F, 5, 1);
    step(1, 1, 'h2A, 5, 1);
    repeat (9) step(0, 1, 0, 5, 1);   // drain, with one pop on empty

    // asynchronous reset with four words stored
    repeat (4) step(1, 0, $urandom_range(0, 63), 5, 1);
    step(0, 0, 0, 5, 1);
    @(negedge clk);
    check_flags();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async fifo_empty", fifo_empty, 1);
    chk("async error",      error,      0);
    check_flags();
    @(negedge clk);
    reset = 1'b1;

    // occupancy 3, then both thresholds cross at the same time
    repeat (3) step(1, 0, $urandom_range(0, 63), 5, 1);
    step(0, 0, 0, 2, 3);
    step(0, 0, 0, 2, 3);
    @(negedge clk);
    chk("both af", almost_full, 1);
    chk("both ae", almost_empty, 1);

    // randomized traffic
    ua_r = 5; ub_r = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        ua_r = $urandom_range(0, 7);
        ub_r = $urandom_range(0, 7);
      end
      step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0 ? 1'b1 : ($urandom_range(0, 1) == 1),
           $urandom_range(0, 63), ua_r, ub_r);
    end
    step(0, 0, 0, ua_r, ub_r);
    @(negedge clk);
    chk("scoreboard drained", expq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_umbral.md
Name: fifo_umbral

Overview:
- Per-lane data FIFO sitting downstream of the configuration FSM.
- Consumes the FSM's latched thresholds (interno_alto/interno_bajo) and produces the empty indication the FSM reads back on its FIFO_empty bus (one instance per bit).
- Generates almost_full/almost_empty flow-control flags from live occupancy against those thresholds.
- Flags overflow/underflow with a sticky error.

Parameters:
- DATA_WIDTH, 6, width of data_in/data_out.
- ADDR_WIDTH, 3, log2 of depth (depth 8); also the threshold width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- push  input  1  write request.
- pop  input  1  read request.
- data_in  input  DATA_WIDTH  write data.
- umbral_alto  input  ADDR_WIDTH  almost-full threshold, driven from FSM interno_alto.
- umbral_bajo  input  ADDR_WIDTH  almost-empty threshold, driven from FSM interno_bajo.
- data_out  output  DATA_WIDTH  read data, registered.
- valid_out  output  1  data_out holds a newly popped word this cycle.
- fifo_empty  output  1  occupancy == 0.
- fifo_full  output  1  occupancy == 2**ADDR_WIDTH.
- almost_full  output  1  occupancy >= umbral_alto.
- almost_empty  output  1  occupancy <= umbral_bajo.
- error  output  1  sticky overflow/underflow indicator.

Behaviour:
- Reset (reset==0, async):
  - wr_ptr=0, rd_ptr=0, count=0.
  - data_out=0, valid_out=0, error=0.
  - Hence fifo_empty=1, fifo_full=0, almost_empty=1, and almost_full=(umbral_alto==0).
  - Memory contents are not reset.
  - Reset mid-operation discards all contents immediately.
- Counter and pointers:
  - count is ADDR_WIDTH+1 bits, range 0..8.
  - Pointers are ADDR_WIDTH bits and wrap 7->0 naturally.
- Push accepted iff push && (!fifo_full || pop_accepted):
  - write mem[wr_ptr]=data_in, then wr_ptr++.
- Pop accepted iff pop && !fifo_empty:
  - data_out <= mem[rd_ptr] on the same edge, then rd_ptr++.
  - valid_out=1 for exactly the following cycle.
  - Latency from pop assertion to data on data_out: 1 clock.
  - With no accepted pop, valid_out=0 and data_out holds its last value.
- Full, push&&pop: both accepted, count unchanged, no error.
- Empty, push&&pop: push accepted, pop rejected (no read-through), error set.
- Push while full without pop: word dropped, pointers/count unchanged, error set.
- Pop while empty: ignored, error set.
- error stays set until reset.
- count next = count + push_acc - pop_acc.
- Flags (default) are combinational from the registered count and live thresholds.
  - Compare with count vs zero-extended threshold.
  - No consistency check: if umbral_bajo >= umbral_alto, both flags may be 1 simultaneously.
- Thresholds may change at any time; flags follow within the same cycle.

Optional Feature:
- Macro FIFO_REG_FLAGS_EN.
- When defined:
  - almost_full, almost_empty, fifo_empty and fifo_full are registered, computed from next-count and current thresholds.
  - They update on the same edge as count; threshold changes appear one cycle later.
  - Reset values as listed above.
  - almost_full resets to 0.
- When undefined: purely combinational, as above.

Decomposition:
- Shared package fifo_pkg:
  - FIFO_DATA_WIDTH=6 and FIFO_ADDR_WIDTH=3 defaults.
  - FIFO_DEPTH=1<<FIFO_ADDR_WIDTH.
- One natural sub-module, fifo_mem:
  - Dual-port register array, synchronous write, synchronous read-enable output register.
  - Instantiated once.
  - Pointer/count/flag logic stays in fifo_umbral.

Test Plan:
- Reset with umbral_alto=5, umbral_bajo=1 -> fifo_empty=1, almost_empty=1, almost_full=0, error=0, valid_out=0.
- Push 0x11,0x22,0x33,0x04,0x05 on consecutive cycles -> count=5, almost_full asserts on the edge of the 5th push, almost_empty deasserts after the 2nd push.
- Pop 5 times -> data_out 0x11,0x22,0x33,0x04,0x05, each one cycle after its pop with valid_out=1; fifo_empty=1 at end.
- Fill to 8, then push 0x3F alone -> fifo_full=1, word dropped, error=1; then push+pop together -> count stays 8, no further change.
- Empty FIFO, pop -> no valid_out, error=1; assert reset=0 mid-stream with count=4 -> count=0, fifo_empty=1 immediately (asynchronous).
- count=3, change thresholds to umbral_alto=2, umbral_bajo=3 -> almost_full=1 and almost_empty=1 same cycle (one cycle later with FIFO_REG_FLAGS_EN).
